// File: rtl/ram_sp_arbiter.sv
// Two-client arbiter for one single-port synchronous RAM with round-robin ties and lockable ownership.
// Define RAM_SP_ARBITER_FIXED_PRIO_EN to make client 0 win every tie in IDLE.
module ram_sp_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_req0,
   input  logic                  i_req1,
   input  logic                  i_lock0,
   input  logic                  i_lock1,
   input  logic                  i_we0,
   input  logic                  i_we1,
   input  logic [ADDR_WIDTH-1:0] i_addr0,
   input  logic [ADDR_WIDTH-1:0] i_addr1,
   input  logic [DATA_WIDTH-1:0] i_wdata0,
   input  logic [DATA_WIDTH-1:0] i_wdata1,
   output logic                  o_gnt0,
   output logic                  o_gnt1,
   output logic                  o_rvalid0,
   output logic                  o_rvalid1,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_ram_we,
   output logic [ADDR_WIDTH-1:0] o_ram_addr,
   output logic [DATA_WIDTH-1:0] o_ram_wdata,
   input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OWN0 = 2'd1;
   localparam logic [1:0] ST_OWN1 = 2'd2;

   logic [1:0] state;
   logic       ptr;
   logic       tie_to0;

`ifdef RAM_SP_ARBITER_FIXED_PRIO_EN
   // The pointer is still tracked but never decides a tie in this build.
   assign tie_to0 = 1'b1 | ptr;
`else
   assign tie_to0 = ptr;
`endif

   always_comb begin
      o_gnt0 = 1'b0;
      o_gnt1 = 1'b0;
      if (!i_reset) begin
         case (state)
            ST_IDLE: begin
               if (i_req0 && i_req1) begin
                  o_gnt0 = tie_to0;
                  o_gnt1 = !tie_to0;
               end else begin
                  o_gnt0 = i_req0;
                  o_gnt1 = i_req1;
               end
            end
            ST_OWN0: o_gnt0 = i_req0;
            ST_OWN1: o_gnt1 = i_req1;
            default: ;
         endcase
      end
   end

   // Client 0's command sits on the bus when nobody is granted; only the write enable matters then.
   assign o_ram_we    = (o_gnt0 && i_we0) || (o_gnt1 && i_we1);
   assign o_ram_addr  = o_gnt1 ? i_addr1  : i_addr0;
   assign o_ram_wdata = o_gnt1 ? i_wdata1 : i_wdata0;
   assign o_rdata     = i_ram_rdata;

   // A cycle without a grant always lands in IDLE, which also releases an owner that dropped its request.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= ST_IDLE;
         ptr       <= 1'b1;
         o_rvalid0 <= 1'b0;
         o_rvalid1 <= 1'b0;
      end else begin
         o_rvalid0 <= o_gnt0 && !i_we0;
         o_rvalid1 <= o_gnt1 && !i_we1;
         if (o_gnt0) begin
            ptr   <= 1'b0;
            state <= i_lock0 ? ST_OWN0 : ST_IDLE;
         end else if (o_gnt1) begin
            ptr   <= 1'b1;
            state <= i_lock1 ? ST_OWN1 : ST_IDLE;
         end else begin
            state <= ST_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Directed bench for ram_sp_arbiter with a behavioural read-before-write RAM attached.
// Tie-break expectations follow RAM_SP_ARBITER_FIXED_PRIO_EN when it is defined.
module tb_ram_sp_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0, req1, lock0, lock1, we0, we1;
   logic [7:0] addr0, addr1, wdata0, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1, ram_we;
   logic [7:0] rdata, ram_addr, ram_wdata;
   logic [7:0] ram_rdata;
   logic [7:0] mem [256];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ram_sp_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_req0(req0), .i_req1(req1), .i_lock0(lock0), .i_lock1(lock1),
      .i_we0(we0), .i_we1(we1), .i_addr0(addr0), .i_addr1(addr1),
      .i_wdata0(wdata0), .i_wdata1(wdata1),
      .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
      .o_rdata(rdata), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
      .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
   );

   // Registered read of the old contents, write takes effect at the same edge.
   always @(posedge clk) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_wdata;
   end

   task automatic set_c0(input logic r, input logic l, input logic w, input logic [7:0] a, input logic [7:0] d);
      req0 = r; lock0 = l; we0 = w; addr0 = a; wdata0 = d;
   endtask

   task automatic set_c1(input logic r, input logic l, input logic w, input logic [7:0] a, input logic [7:0] d);
      req1 = r; lock1 = l; we1 = w; addr1 = a; wdata1 = d;
   endtask

   task automatic idle_all();
      set_c0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_c1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic test_reset();
      set_c0(1'b1, 1'b0, 1'b1, 8'h10, 8'hFF);
      #12;
      vectors++;
      if ({gnt0, gnt1} !== 2'b00) begin
         miscompares++; $display("[TB] FAIL reset_gnt: got %b expected 00", {gnt0, gnt1});
      end
      vectors++;
      if (ram_we !== 1'b0) begin
         miscompares++; $display("[TB] FAIL reset_ram_we: got %b expected 0", ram_we);
      end
      vectors++;
      if ({rvalid0, rvalid1} !== 2'b00) begin
         miscompares++; $display("[TB] FAIL reset_rvalid: got %b expected 00", {rvalid0, rvalid1});
      end
      @(negedge clk);
      reset = 1'b0;
      idle_all();
      @(negedge clk);
   endtask

   task automatic test_write_read();
      set_c0(1'b1, 1'b0, 1'b1, 8'h10, 8'hA5);
      #1;
      vectors++;
      if ({gnt0, gnt1, ram_we, ram_addr, ram_wdata} !== {3'b101, 8'h10, 8'hA5}) begin
         miscompares++; $display("[TB] FAIL wr_drive: got %b%b%b %h %h expected 101 10 a5", gnt0, gnt1, ram_we, ram_addr, ram_wdata);
      end
      @(negedge clk);
      vectors++;
      if ({rvalid0, rvalid1} !== 2'b00) begin
         miscompares++; $display("[TB] FAIL wr_no_rvalid: got %b expected 00", {rvalid0, rvalid1});
      end
      set_c0(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
      #1;
      vectors++;
      if ({gnt0, gnt1, ram_we} !== 3'b100) begin
         miscompares++; $display("[TB] FAIL rd_gnt: got %b expected 100", {gnt0, gnt1, ram_we});
      end
      @(negedge clk);
      vectors++;
      if ({rvalid0, rvalid1} !== 2'b10 || rdata !== 8'hA5) begin
         miscompares++; $display("[TB] FAIL rd_data: got %b %h expected 10 a5", {rvalid0, rvalid1}, rdata);
      end
      idle_all();
      #1;
      vectors++;
      if ({gnt0, gnt1, ram_we} !== 3'b000) begin
         miscompares++; $display("[TB] FAIL no_req_idle: got %b expected 000", {gnt0, gnt1, ram_we});
      end
      @(negedge clk);
   endtask

   // Leaves the pointer on client 1 so the next tie goes to client 0.
   task automatic test_preload();
      set_c0(1'b1, 1'b0, 1'b1, 8'h01, 8'h11);
      @(negedge clk);
      set_c0(1'b1, 1'b0, 1'b1, 8'h30, 8'h5A);
      @(negedge clk);
      set_c0(1'b1, 1'b0, 1'b1, 8'h20, 8'h40);
      @(negedge clk);
      idle_all();
      set_c1(1'b1, 1'b0, 1'b1, 8'h02, 8'h22);
      #1;
      vectors++;
      if ({gnt0, gnt1, ram_addr, ram_wdata} !== {2'b01, 8'h02, 8'h22}) begin
         miscompares++; $display("[TB] FAIL c1_write_drive: got %b %h %h expected 01 02 22", {gnt0, gnt1}, ram_addr, ram_wdata);
      end
      @(negedge clk);
      idle_all();
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g;
      set_c0(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
      set_c1(1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
      for (int i = 0; i < 6; i++) begin
`ifdef RAM_SP_ARBITER_FIXED_PRIO_EN
         exp_g = 2'b10;
`else
         exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
`endif
         #1;
         vectors++;
         if ({gnt0, gnt1} !== exp_g) begin
            miscompares++; $display("[TB] FAIL tie_gnt[%0d]: got %b expected %b", i, {gnt0, gnt1}, exp_g);
         end
         @(negedge clk);
         vectors++;
         if ({rvalid0, rvalid1} !== exp_g || rdata !== ((exp_g == 2'b10) ? 8'h11 : 8'h22)) begin
            miscompares++; $display("[TB] FAIL tie_rvalid[%0d]: got %b %h expected %b %h", i, {rvalid0, rvalid1}, rdata, exp_g, (exp_g == 2'b10) ? 8'h11 : 8'h22);
         end
      end
      idle_all();
      @(negedge clk);
   endtask

   task automatic test_lone();
      set_c1(1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if ({gnt0, gnt1} !== 2'b01) begin
            miscompares++; $display("[TB] FAIL lone_gnt[%0d]: got %b expected 01", i, {gnt0, gnt1});
         end
         @(negedge clk);
         vectors++;
         if ({rvalid0, rvalid1} !== 2'b01 || rdata !== 8'h22) begin
            miscompares++; $display("[TB] FAIL lone_rvalid[%0d]: got %b %h expected 01 22", i, {rvalid0, rvalid1}, rdata);
         end
      end
      idle_all();
      @(negedge clk);
   endtask

   task automatic test_lock_rmw();
      set_c1(1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
      #1;
      vectors++;
      if ({gnt0, gnt1} !== 2'b01) begin
         miscompares++; $display("[TB] FAIL rmw_rd_gnt: got %b expected 01", {gnt0, gnt1});
      end
      @(negedge clk);
      vectors++;
      if ({rvalid0, rvalid1} !== 2'b01 || rdata !== 8'h40) begin
         miscompares++; $display("[TB] FAIL rmw_rd_data: got %b %h expected 01 40", {rvalid0, rvalid1}, rdata);
      end
      set_c0(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
      set_c1(1'b1, 1'b0, 1'b1, 8'h20, 8'h41);
      #1;
      vectors++;
      if ({gnt0, gnt1, ram_we} !== 3'b011) begin
         miscompares++; $display("[TB] FAIL rmw_wr_locked_out: got %b expected 011", {gnt0, gnt1, ram_we});
      end
      @(negedge clk);
      set_c1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      vectors++;
      if ({gnt0, gnt1, rvalid1} !== 3'b100) begin
         miscompares++; $display("[TB] FAIL rmw_c0_after: got %b expected 100", {gnt0, gnt1, rvalid1});
      end
      @(negedge clk);
      vectors++;
      if ({rvalid0, rvalid1} !== 2'b10 || rdata !== 8'hA5) begin
         miscompares++; $display("[TB] FAIL rmw_c0_data: got %b %h expected 10 a5", {rvalid0, rvalid1}, rdata);
      end
      idle_all();
      set_c1(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
      @(negedge clk);
      vectors++;
      if ({rvalid0, rvalid1} !== 2'b01 || rdata !== 8'h41) begin
         miscompares++; $display("[TB] FAIL rmw_result: got %b %h expected 01 41", {rvalid0, rvalid1}, rdata);
      end
      idle_all();
      @(negedge clk);
   endtask

   task automatic test_lock_release();
      set_c0(1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
      @(negedge clk);
      set_c0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_c1(1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
      #1;
      vectors++;
      if ({gnt0, gnt1} !== 2'b00) begin
         miscompares++; $display("[TB] FAIL release_gap: got %b expected 00", {gnt0, gnt1});
      end
      @(negedge clk);
      #1;
      vectors++;
      if ({gnt0, gnt1} !== 2'b01) begin
         miscompares++; $display("[TB] FAIL release_then_c1: got %b expected 01", {gnt0, gnt1});
      end
      @(negedge clk);
      idle_all();
      @(negedge clk);
   endtask

   task automatic test_rbw();
      set_c0(1'b1, 1'b0, 1'b0, 8'h30, 8'h00);
      @(negedge clk);
      set_c0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_c1(1'b1, 1'b0, 1'b1, 8'h30, 8'hC3);
      #1;
      vectors++;
      if ({gnt0, gnt1, rvalid0} !== 3'b011 || rdata !== 8'h5A) begin
         miscompares++; $display("[TB] FAIL rbw_old: got %b %h expected 011 5a", {gnt0, gnt1, rvalid0}, rdata);
      end
      @(negedge clk);
      set_c1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_c0(1'b1, 1'b0, 1'b0, 8'h30, 8'h00);
      @(negedge clk);
      vectors++;
      if ({rvalid0, rvalid1} !== 2'b10 || rdata !== 8'hC3) begin
         miscompares++; $display("[TB] FAIL rbw_new: got %b %h expected 10 c3", {rvalid0, rvalid1}, rdata);
      end
      idle_all();
      @(negedge clk);
   endtask

   task automatic test_lock_reset();
      set_c1(1'b1, 1'b1, 1'b0, 8'h01, 8'h00);
      @(negedge clk);
      vectors++;
      if ({rvalid0, rvalid1} !== 2'b01 || rdata !== 8'h11) begin
         miscompares++; $display("[TB] FAIL lr_rd_data: got %b %h expected 01 11", {rvalid0, rvalid1}, rdata);
      end
      set_c0(1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
      set_c1(1'b1, 1'b1, 1'b1, 8'h50, 8'h99);
      #1;
      vectors++;
      if ({gnt0, gnt1, ram_we} !== 3'b011) begin
         miscompares++; $display("[TB] FAIL lr_owned: got %b expected 011", {gnt0, gnt1, ram_we});
      end
      #1 reset = 1'b1;
      #1;
      vectors++;
      if ({rvalid0, rvalid1, gnt0, gnt1, ram_we} !== 5'b00000) begin
         miscompares++; $display("[TB] FAIL lr_reset_clear: got %b expected 00000", {rvalid0, rvalid1, gnt0, gnt1, ram_we});
      end
      @(negedge clk);
      reset = 1'b0;
      set_c1(1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
      #1;
      vectors++;
      if ({gnt0, gnt1} !== 2'b10) begin
         miscompares++; $display("[TB] FAIL lr_idle_after: got %b expected 10", {gnt0, gnt1});
      end
      @(negedge clk);
      vectors++;
      if ({rvalid0, rvalid1} !== 2'b10 || rdata !== 8'h22) begin
         miscompares++; $display("[TB] FAIL lr_c0_data: got %b %h expected 10 22", {rvalid0, rvalid1}, rdata);
      end
      idle_all();
      @(negedge clk);
   endtask

   initial begin
      idle_all();
      test_reset();
      test_write_read();
      test_preload();
      test_round_robin();
      test_lone();
      test_lock_rmw();
      test_lock_release();
      test_rbw();
      test_lock_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ram_sp_arbiter.md
Name: ram_sp_arbiter

Overview:
- Two-client arbiter that shares one single-port synchronous RAM (ram_sp: 1-cycle read latency, read-before-write).
- Each cycle it grants at most one client, muxes that client's command onto the RAM port, and steers returned read data back with a per-client valid strobe.
- Supports round-robin fairness and a lock for atomic multi-cycle sequences such as read-modify-write.
- Sits between the RAM and two masters, for example a CPU-side port and a DMA or display engine.

Parameters:
- ADDR_WIDTH, 8, RAM address width; must match the attached RAM.
- DATA_WIDTH, 8, RAM data width; must match the attached RAM.

Ports:
- i_clk  input  1  system clock; all state changes on the rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_req0 / i_req1  input  1  client k requests one RAM access this cycle; held with the command until granted.
- i_lock0 / i_lock1  input  1  client k keeps ownership after this grant.
- i_we0 / i_we1  input  1  client k command is a write (1) or a read (0).
- i_addr0 / i_addr1  input  ADDR_WIDTH  client k address.
- i_wdata0 / i_wdata1  input  DATA_WIDTH  client k write data.
- o_gnt0 / o_gnt1  output  1  combinational; client k's command is accepted on this clock edge.
- o_rvalid0 / o_rvalid1  output  1  registered; o_rdata carries client k's read result this cycle.
- o_rdata  output  DATA_WIDTH  read data, passed through from i_ram_rdata.
- o_ram_we  output  1  RAM write enable.
- o_ram_addr  output  ADDR_WIDTH  RAM address.
- o_ram_wdata  output  DATA_WIDTH  RAM write data.
- i_ram_rdata  input  DATA_WIDTH  RAM registered read data.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, last-granted pointer=1 (so client 0 wins the first tie), o_rvalid0=o_rvalid1=0.
  - While i_reset is high: o_gnt0=o_gnt1=0 and o_ram_we=0.
- Handshake:
  - A request is a (req, we, addr, wdata) tuple held stable until o_gntk=1.
  - o_gntk=1 means the tuple is consumed at that edge.
  - At most one o_gnt is high per cycle. Throughput is one access per cycle.
- RAM drive:
  - In a grant cycle, o_ram_addr, o_ram_wdata and o_ram_we come from the granted client.
  - With no grant: o_ram_we=0, and o_ram_addr/o_ram_wdata hold client 0's values (don't-care).
- Read latency:
  - A read granted in cycle N produces o_rvalidk=1 in cycle N+1, with o_rdata = the RAM contents at that address before any cycle-N write.
  - A granted write produces no rvalid.
  - o_rvalidk must never be high for a client that was not granted a read in the previous cycle.
- State machine:
  - IDLE:
    - Only one requester: grant it.
    - Both request: grant the client not equal to the pointer.
    - After a grant: pointer := granted client. If that client's i_lock is high, go to OWNk; otherwise stay in IDLE.
  - OWNk:
    - Only client k can be granted; the other client's request waits with o_gnt=0.
    - Grant k with lock=0: return to IDLE, pointer := k.
    - Grant k with lock=1: stay in OWNk.
    - i_reqk low in OWNk: ownership released, return to IDLE with no grant that cycle.
- Boundary cases:
  - Simultaneous requests in back-to-back cycles alternate 0,1,0,1.
  - A lone requester is granted every cycle.
  - Reset mid-lock forces IDLE.
  - Reset asserted the cycle after a read grant clears o_rvalid immediately, with no late strobe.
  - Address wrap is the RAM's; no arithmetic is done here.

Optional Feature:
- Macro RAM_SP_ARBITER_FIXED_PRIO_EN.
- Defined: in IDLE, client 0 always wins ties. The pointer is still updated but ignored for tie-breaks. Lock behaviour is unchanged.
- Undefined (default): round-robin tie-break as described above.

Test Plan:
- Reset then idle: i_reset pulse mid-cycle -> o_rvalid0/1=0 immediately; no o_gnt and o_ram_we=0 while reset is high.
- Client 0 writes 0xA5 to addr 0x10, then reads 0x10 -> o_gnt0 in each request cycle; o_rvalid0 one cycle after the read grant with o_rdata=0xA5; o_rvalid1 stays 0.
- Both clients hold read requests for 6 cycles (addr 0x01 / 0x02, preloaded 0x11 / 0x22) -> grants alternate 0,1,0,1,0,1; rvalid alternates one cycle behind with data 0x11/0x22.
- Client 1 locked RMW: read 0x20 with lock=1, then write 0x20 with lock=0, while client 0 requests continuously -> client 0 is not granted until the cycle after client 1's unlocked write.
- Read-before-write: client 0 reads 0x30 (old 0x5A) and client 1 writes 0x30 = 0xC3 in the next cycle -> client 0 gets 0x5A; a subsequent read returns 0xC3.
- With RAM_SP_ARBITER_FIXED_PRIO_EN defined and both requesting for 4 cycles -> o_gnt0 every cycle, o_gnt1 never.
